// File: rtl/spad_quench_ctrl.sv
// -----------------------------------------------------------------------------
// spad_quench_ctrl
//
// Quench/recharge controller for a SPAD pixel, plus a per-frame photon counter.
// trig and time_gate are brought into the clk domain through SYNC_STAGES flops.
// A rising trig while ARMED (and en=1) is accepted as a photon. The pixel is then
// quenched (rst_auto high) for QUENCH_CYC cycles once sync arrives with the gate
// closed. It is re-armed after a HOLDOFF_CYC recharge, provided trig has cleared.
// If trig is still high after TIMEOUT_CYC recharge cycles, the sticky err_stuck
// flag is set and the pixel is quenched again.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   trig       in   SPAD trigger (asynchronous level)
//   time_gate  in   SPAD gate window (asynchronous level)
//   sync       in   sync strobe, clk domain
//   en         in   1 = accept new hits while ARMED
//   frame      in   1-cycle pulse closing the count window
//   rst_auto   out  SPAD reset/quench, registered (1 during reset)
//   hit        out  1-cycle pulse per accepted photon
//   armed      out  high while ARMED
//   cnt_out    out  hit count of the last closed window
//   cnt_valid  out  1-cycle pulse when cnt_out/cnt_ovf are updated
//   cnt_ovf    out  the closed window lost hits to saturation
//   err_stuck  out  sticky: trig failed to clear during recharge
// -----------------------------------------------------------------------------
module spad_quench_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned QUENCH_CYC  = 8,
   parameter int unsigned HOLDOFF_CYC = 16,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic             time_gate,
   input  logic             sync,
   input  logic             en,
   input  logic             frame,
   output logic             rst_auto,
   output logic             hit,
   output logic             armed,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_valid,
   output logic             cnt_ovf,
   output logic             err_stuck
);

   localparam int unsigned CYC_MAX = (QUENCH_CYC > TIMEOUT_CYC) ? QUENCH_CYC : TIMEOUT_CYC;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

   // Last cycle index of each timed phase (the phase counter starts at 0 on entry).
   localparam logic [CYC_W-1:0] QUENCH_LAST  = CYC_W'(QUENCH_CYC - 1);
   localparam logic [CYC_W-1:0] HOLDOFF_LAST = CYC_W'(HOLDOFF_CYC - 1);
   localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_ARMED,
      S_FIRED,
      S_QUENCH,
      S_RECOVER
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] trig_sync, tg_sync;
   logic                   trig_s, tg_s, trig_s_d, rise;
   logic [CYC_W-1:0]       cyc_cnt;
   logic                   hit_nxt, stuck_nxt;
   logic [CNT_W-1:0]       count;
   logic                   ovf;

   // ---------------------------------------------------------------- synchronizers
   assign trig_s = trig_sync[SYNC_STAGES-1];
   assign tg_s   = tg_sync[SYNC_STAGES-1];
   assign rise   = trig_s & ~trig_s_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         trig_sync <= '0;
         tg_sync   <= '0;
         trig_s_d  <= 1'b0;
      end else begin
         trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig};
         tg_sync   <= {tg_sync[SYNC_STAGES-2:0], time_gate};
         trig_s_d  <= trig_s;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RECOVER;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hit_nxt   = 1'b0;
      stuck_nxt = 1'b0;
      case (state)
         S_ARMED: begin
            if (rise && en) begin
               state_nxt = S_FIRED;
               hit_nxt   = 1'b1;
            end
         end
         S_FIRED: begin
            if (sync && !tg_s) begin
               state_nxt = S_QUENCH;
            end
         end
         S_QUENCH: begin
            if (cyc_cnt == QUENCH_LAST) begin
               state_nxt = S_RECOVER;
            end
         end
         S_RECOVER: begin
            if ((cyc_cnt >= HOLDOFF_LAST) && !trig_s) begin
               state_nxt = S_ARMED;
            end else if (cyc_cnt == TIMEOUT_LAST) begin
               state_nxt = S_QUENCH;
               stuck_nxt = 1'b1;
            end
         end
         default: state_nxt = S_RECOVER;
      endcase
   end

   // Phase counter: restarts on every state change, so QUENCH and RECOVER
   // each count from 0 on entry (including re-entry after a stuck timeout).
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt <= '0;
      end else if (state_nxt != state) begin
         cyc_cnt <= '0;
      end else if ((state == S_QUENCH) || (state == S_RECOVER)) begin
         cyc_cnt <= cyc_cnt + 1'b1;
      end
   end

   // rst_auto is registered from the next state so that it is high exactly
   // during the QUENCH_CYC cycles the FSM spends in QUENCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_auto  <= 1'b1;
         hit       <= 1'b0;
         err_stuck <= 1'b0;
      end else begin
         rst_auto  <= (state_nxt == S_QUENCH);
         hit       <= hit_nxt;
         err_stuck <= err_stuck | stuck_nxt;
      end
   end

   assign armed = (state == S_ARMED);

   // ---------------------------------------------------------------- hit counter
   // Counts the registered hit pulse. A hit in the frame cycle opens the new
   // window with a count of 1. ovf records that a hit was lost to saturation.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         ovf       <= 1'b0;
         cnt_out   <= '0;
         cnt_ovf   <= 1'b0;
         cnt_valid <= 1'b0;
      end else begin
         cnt_valid <= frame;
         if (frame) begin
            cnt_out <= count;
            cnt_ovf <= ovf;
            count   <= {{(CNT_W-1){1'b0}}, hit};
            ovf     <= 1'b0;
         end else if (hit) begin
            if (count == '1) begin
               ovf <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spad_quench_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spad_quench_ctrl
//
// Scoreboard bench for spad_quench_ctrl. Stimulus tasks push the expected
// timing of each response (hit pulse, quench window, re-arm, cnt_valid with
// count/ovf, err_stuck rise) into queues; a monitor sampling 1 time unit after
// each rising edge pops and compares whenever the DUT presents that response.
// Cycle numbers: a sample labelled k is taken after rising edge k.
// -----------------------------------------------------------------------------
module tb_spad_quench_ctrl;

   localparam int SYNC = 2;
   localparam int Q    = 8;
   localparam int H    = 16;
   localparam int T    = 64;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, trig, time_gate, sync, en, frame;
   logic          rst_auto, hit, armed, cnt_valid, cnt_ovf, err_stuck;
   logic [CW-1:0] cnt_out;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of the current count window.
   int m_count = 0;
   int m_ovf   = 0;

   typedef struct {
      int cyc;
      int cnt;
      int ovf;
   } cv_t;

   typedef struct {
      int start;
      int width;
   } qp_t;

   int  hit_q[$];
   int  arm_q[$];
   int  err_q[$];
   cv_t cv_q[$];
   qp_t qp_q[$];

   spad_quench_ctrl #(
      .SYNC_STAGES(SYNC),
      .QUENCH_CYC (Q),
      .HOLDOFF_CYC(H),
      .TIMEOUT_CYC(T),
      .CNT_W      (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .trig     (trig),
      .time_gate(time_gate),
      .sync     (sync),
      .en       (en),
      .frame    (frame),
      .rst_auto (rst_auto),
      .hit      (hit),
      .armed    (armed),
      .cnt_out  (cnt_out),
      .cnt_valid(cnt_valid),
      .cnt_ovf  (cnt_ovf),
      .err_stuck(err_stuck)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_hit();
      if (m_count == CMAX) m_ovf = 1;
      else m_count++;
   endfunction

   function automatic void push_frame(input int at);
      cv_t t;
      t.cyc = at;
      t.cnt = m_count;
      t.ovf = m_ovf;
      cv_q.push_back(t);
   endfunction

   function automatic void push_quench(input int start);
      qp_t t;
      t.start = start;
      t.width = Q;
      qp_q.push_back(t);
   endfunction

   // ------------------------------------------------------------------ monitor
   logic ra_prev = 1'b1;
   logic ar_prev = 1'b0;
   logic es_prev = 1'b0;
   logic in_q    = 1'b0;
   int   q_start = 0;
   cv_t  mon_cv;
   qp_t  mon_qp;

   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         in_q = 1'b0;
      end else begin
         if (hit) begin
            if (hit_q.size() == 0) chk("hit_unexpected", 1, 0);
            else chk("hit_cycle", cyc, hit_q.pop_front());
         end
         if (cnt_valid) begin
            if (cv_q.size() == 0) begin
               chk("cnt_valid_unexpected", 1, 0);
            end else begin
               mon_cv = cv_q.pop_front();
               chk("cnt_valid_cycle", cyc, mon_cv.cyc);
               chk("cnt_out", int'(cnt_out), mon_cv.cnt);
               chk("cnt_ovf", int'(cnt_ovf), mon_cv.ovf);
            end
         end
         if (armed && !ar_prev) begin
            if (arm_q.size() == 0) chk("armed_unexpected", 1, 0);
            else chk("armed_cycle", cyc, arm_q.pop_front());
         end
         if (err_stuck && !es_prev) begin
            if (err_q.size() == 0) chk("err_stuck_unexpected", 1, 0);
            else chk("err_stuck_cycle", cyc, err_q.pop_front());
         end
         if (rst_auto && !ra_prev) begin
            in_q    = 1'b1;
            q_start = cyc;
         end else if (!rst_auto && ra_prev && in_q) begin
            in_q = 1'b0;
            if (qp_q.size() == 0) begin
               chk("quench_unexpected", 1, 0);
            end else begin
               mon_qp = qp_q.pop_front();
               chk("quench_start", q_start, mon_qp.start);
               chk("quench_width", cyc - q_start, mon_qp.width);
            end
         end
      end
      ra_prev = rst_auto;
      ar_prev = armed;
      es_prev = err_stuck;
   end

   // ------------------------------------------------------------------ stimulus
   task automatic wait_armed(input string name);
      int i = 0;
      while (!armed && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk(name, int'(armed), 1);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1; trig = 1'b0; sync = 1'b0; frame = 1'b0; time_gate = 1'b1;
      hit_q.delete(); arm_q.delete(); err_q.delete(); cv_q.delete(); qp_q.delete();
      m_count = 0;
      m_ovf   = 0;
      repeat (n) @(negedge clk);
      chk("rst_rst_auto", int'(rst_auto), 1);
      chk("rst_hit", int'(hit), 0);
      chk("rst_armed", int'(armed), 0);
      chk("rst_cnt_out", int'(cnt_out), 0);
      chk("rst_cnt_valid", int'(cnt_valid), 0);
      chk("rst_cnt_ovf", int'(cnt_ovf), 0);
      chk("rst_err_stuck", int'(err_stuck), 0);
      rst = 1'b0;
      arm_q.push_back(cyc + H);
      @(negedge clk);
      chk("rst_auto_release", int'(rst_auto), 0);
      wait_armed("armed_after_reset");
   endtask

   task automatic do_frame();
      @(negedge clk);
      frame = 1'b1;
      push_frame(cyc + 1);
      m_count = 0;
      m_ovf   = 0;
      @(negedge clk);
      frame = 1'b0;
   endtask

   // One full photon event starting from ARMED. With en_v=0 the edge must be ignored.
   task automatic photon(input bit en_v, input bit frame_on_hit);
      int c, s;
      @(negedge clk);
      en = en_v; trig = 1'b1; time_gate = 1'b1;
      c = cyc;
      if (!en_v) begin
         repeat (SYNC + 3) @(negedge clk);
         chk("armed_hold_en0", int'(armed), 1);
         trig = 1'b0;
         repeat (SYNC + 1) @(negedge clk);
         return;
      end
      hit_q.push_back(c + SYNC + 1);
      repeat (SYNC + 1) @(negedge clk);
      chk("armed_after_hit", int'(armed), 0);
      if (frame_on_hit) begin
         frame = 1'b1;
         push_frame(cyc + 1);
         m_count = 1;
         m_ovf   = 0;
      end else begin
         model_hit();
      end
      @(negedge clk);
      frame = 1'b0; trig = 1'b0; time_gate = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      sync = 1'b1;
      s = cyc;
      push_quench(s + 1);
      arm_q.push_back(s + Q + H + 1);
      @(negedge clk);
      sync = 1'b0; time_gate = 1'b1;
      wait_armed("armed_rearm");
   endtask

   task automatic stuck_test();
      int c, s, q2;
      @(negedge clk);
      en = 1'b1; trig = 1'b1; time_gate = 1'b1;
      c = cyc;
      hit_q.push_back(c + SYNC + 1);
      repeat (SYNC + 1) @(negedge clk);
      model_hit();
      @(negedge clk);
      time_gate = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      sync = 1'b1;
      s  = cyc;
      q2 = s + Q + T + 1;
      push_quench(s + 1);
      push_quench(q2);
      err_q.push_back(q2);
      arm_q.push_back(q2 + Q + H);
      @(negedge clk);
      sync = 1'b0; time_gate = 1'b1;
      while (cyc < q2 + 2) @(negedge clk);
      chk("err_stuck_set", int'(err_stuck), 1);
      chk("rst_auto_requench", int'(rst_auto), 1);
      trig = 1'b0;
      wait_armed("armed_after_stuck");
      chk("err_stuck_sticky", int'(err_stuck), 1);
      photon(1'b1, 1'b0);
      chk("err_stuck_sticky2", int'(err_stuck), 1);
   endtask

   task automatic reset_in_quench();
      int s;
      @(negedge clk);
      en = 1'b1; trig = 1'b1; time_gate = 1'b1;
      hit_q.push_back(cyc + SYNC + 1);
      repeat (SYNC + 1) @(negedge clk);
      model_hit();
      @(negedge clk);
      trig = 1'b0; time_gate = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      sync = 1'b1;
      s = cyc;
      @(negedge clk);
      sync = 1'b0; time_gate = 1'b1;
      while (cyc < s + 3) @(negedge clk);
      chk("rst_auto_in_quench", int'(rst_auto), 1);
      do_reset(2);
   endtask

   initial begin
      rst = 1'b1; trig = 1'b0; time_gate = 1'b1; sync = 1'b0; en = 1'b1; frame = 1'b0;

      do_reset(3);

      photon(1'b1, 1'b0);
      do_frame();

      repeat (5) photon(1'b1, 1'b0);
      do_frame();
      photon(1'b1, 1'b1);
      do_frame();

      repeat (20) photon(1'b1, 1'b0);
      do_frame();
      do_frame();

      repeat (3) photon(1'b0, 1'b0);
      do_frame();

      stuck_test();
      do_reset(3);

      reset_in_quench();
      do_frame();

      for (int k = 0; k < 40; k++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 6) photon(1'b1, 1'b0);
         else if (r < 7) photon(1'b0, 1'b0);
         else if (r < 8) photon(1'b1, 1'b1);
         else do_frame();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      do_frame();

      repeat (10) @(negedge clk);
      chk("hit_q_empty", hit_q.size(), 0);
      chk("cv_q_empty", cv_q.size(), 0);
      chk("qp_q_empty", qp_q.size(), 0);
      chk("arm_q_empty", arm_q.size(), 0);
      chk("err_q_empty", err_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
